// File: rtl/he_lb_mem_stub_if.sv
// Bus bundle for the HE-LB memory stub: single-beat write channel, write
// response channel and burst read channel.
interface he_lb_mem_stub_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, arlen, rready,
    input  awready, wready, bvalid, bid, bresp,
           arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, arlen, rready,
    output awready, wready, bvalid, bid, bresp,
           arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/he_lb_mem_stub.sv
// Word-addressed memory stub for HE-LB traffic: byte-strobed single-beat
// writes with an in-order response queue, and fixed-latency burst reads.
module he_lb_mem_stub #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 2,
  parameter int B_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  he_lb_mem_stub_if.slave bus,
  output logic [15:0]     wr_cnt,
  output logic [15:0]     rd_cnt
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BP_W   = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int BC_W   = $clog2(B_DEPTH + 1);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2
  } rd_state_e;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic [ADDR_WIDTH-1:0] aw_addr_s;
  logic [ADDR_WIDTH-1:0] ar_addr_s;
  logic [IDX_W-1:0]      aw_idx_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic                  unused_addr_s;
  logic                  b_full_s;
  logic                  wr_accept_s;
  logic                  b_pop_s;
  logic                  rd_beat_s;
  logic [IDX_W-1:0]      next_idx_s;

  logic [ID_WIDTH-1:0]   bq_q [B_DEPTH];
  logic [BP_W-1:0]       b_wr_ptr_q, b_wr_ptr_d;
  logic [BP_W-1:0]       b_rd_ptr_q, b_rd_ptr_d;
  logic [BC_W-1:0]       b_cnt_q, b_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;

  rd_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [8:0]            beats_q, beats_d;
  logic [3:0]            lat_q, lat_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;

  function automatic logic [BP_W-1:0] b_ptr_inc(input logic [BP_W-1:0] p);
    if (p == BP_W'(B_DEPTH - 1)) begin
      return BP_W'(0);
    end else begin
      return p + BP_W'(1);
    end
  endfunction

  // Address bits above the word index alias onto the same storage.
  assign aw_addr_s     = bus.awaddr;
  assign ar_addr_s     = bus.araddr;
  assign aw_idx_s      = aw_addr_s[OFF_W +: IDX_W];
  assign ar_idx_s      = ar_addr_s[OFF_W +: IDX_W];
  assign unused_addr_s = ^{aw_addr_s, ar_addr_s};

  // Write accept, response queue bookkeeping and write counter.
  always_comb begin
    b_full_s    = (b_cnt_q == BC_W'(B_DEPTH));
    wr_accept_s = bus.awvalid & bus.wvalid & ~b_full_s;
    b_pop_s     = (b_cnt_q != BC_W'(0)) & bus.bready;
    b_wr_ptr_d  = b_wr_ptr_q;
    b_rd_ptr_d  = b_rd_ptr_q;
    b_cnt_d     = b_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (wr_accept_s) begin
      b_wr_ptr_d = b_ptr_inc(b_wr_ptr_q);
      wr_cnt_d   = wr_cnt_q + 16'd1;
    end else begin
      b_wr_ptr_d = b_wr_ptr_q;
    end
    if (b_pop_s) begin
      b_rd_ptr_d = b_ptr_inc(b_rd_ptr_q);
    end else begin
      b_rd_ptr_d = b_rd_ptr_q;
    end
    case ({wr_accept_s, b_pop_s})
      2'b10:   b_cnt_d = b_cnt_q + BC_W'(1);
      2'b01:   b_cnt_d = b_cnt_q - BC_W'(1);
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  // Read FSM: latch the request, count down the latency, then stream beats.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beats_d    = beats_q;
    lat_d      = lat_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rd_beat_s  = 1'b0;
    next_idx_s = idx_q + IDX_W'(1);
    case (state_q)
      RD_IDLE: begin
        if (bus.arvalid) begin
          rid_d   = bus.arid;
          idx_d   = ar_idx_s;
          beats_d = {1'b0, bus.arlen} + 9'd1;
          lat_d   = 4'(RD_LATENCY);
          state_d = RD_WAIT;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd0) begin
          rdata_d  = ram_q[idx_q];
          rvalid_d = 1'b1;
          rlast_d  = (beats_q == 9'd1);
          state_d  = RD_BURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RD_BURST: begin
        if (bus.rready) begin
          rd_beat_s = 1'b1;
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = RD_IDLE;
          end else begin
            idx_d   = next_idx_s;
            beats_d = beats_q - 9'd1;
            rdata_d = ram_q[next_idx_s];
            rlast_d = (beats_q == 9'd2);
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      default: begin
        state_d  = RD_IDLE;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end
    endcase
    if (rd_beat_s) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wstrb[b]) begin
          ram_q[aw_idx_s][b*8 +: 8] <= bus.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < B_DEPTH; i++) begin
        bq_q[i] <= '0;
      end
      b_wr_ptr_q <= '0;
      b_rd_ptr_q <= '0;
      b_cnt_q    <= '0;
      wr_cnt_q   <= 16'd0;
      rd_cnt_q   <= 16'd0;
      state_q    <= RD_IDLE;
      idx_q      <= '0;
      beats_q    <= 9'd0;
      lat_q      <= 4'd0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        bq_q[b_wr_ptr_q] <= bus.awid;
      end
      b_wr_ptr_q <= b_wr_ptr_d;
      b_rd_ptr_q <= b_rd_ptr_d;
      b_cnt_q    <= b_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
      lat_q      <= lat_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
    end
  end

  assign bus.awready = wr_accept_s;
  assign bus.wready  = wr_accept_s;
  assign bus.bvalid  = (b_cnt_q != BC_W'(0));
  assign bus.bid     = bq_q[b_rd_ptr_q];
  assign bus.bresp   = 2'b00;
  assign bus.arready = (state_q == RD_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = 2'b00;
  assign bus.rlast   = rlast_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
endmodule
